// File: rtl/fpu_special_case_pipe_if.sv
// Operand/result beat bundle for the FP add/sub special-case resolver.
// The slave modport is the resolver's view; the master modport is the driver's view.
interface fpu_special_case_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic             i_add_sub;
  logic             i_sign_a;
  logic [EXP_W-1:0] i_exp_a;
  logic [MAN_W:0]   i_man_a;
  logic             i_sign_b;
  logic [EXP_W-1:0] i_exp_b;
  logic [MAN_W:0]   i_man_b;

  logic             o_valid;
  logic             i_ready;
  logic [1:0]       o_sel;
  logic             o_sign;
  logic [EXP_W-1:0] o_exp;
  logic [MAN_W:0]   o_man;

  logic             i_flag_clr;
  logic             o_flag_invalid;
  logic             o_flag_inf;
  logic [CNT_W-1:0] o_nan_cnt;

  modport slave (
    input  i_valid, i_add_sub,
    input  i_sign_a, i_exp_a, i_man_a,
    input  i_sign_b, i_exp_b, i_man_b,
    input  i_ready, i_flag_clr,
    output o_ready, o_valid, o_sel, o_sign, o_exp, o_man,
    output o_flag_invalid, o_flag_inf, o_nan_cnt
  );

  modport master (
    output i_valid, i_add_sub,
    output i_sign_a, i_exp_a, i_man_a,
    output i_sign_b, i_exp_b, i_man_b,
    output i_ready, i_flag_clr,
    input  o_ready, o_valid, o_sel, o_sign, o_exp, o_man,
    input  o_flag_invalid, o_flag_inf, o_nan_cnt
  );
endinterface

// File: rtl/fpu_special_case_pipe.sv
// Special-operand resolver for FP add/sub: classifies A/B, resolves the IEEE special result,
// and carries it through a LAT-deep valid/ready pipeline with sticky flags and a NaN counter.
module fpu_special_case_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LAT   = 2,
  parameter int FTZ   = 1,
  parameter int CNT_W = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  fpu_special_case_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_ARITH = 2'b00,
    SEL_NAN   = 2'b01,
    SEL_INF   = 2'b10,
    SEL_PASS  = 2'b11
  } sel_e;

  typedef struct packed {
    sel_e             sel;
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W:0]   man;
    logic             inv;
  } beat_t;

  localparam logic [MAN_W:0] QNAN_MAN = {2'b01, {(MAN_W-1){1'b0}}};
  localparam bit             FTZ_EN   = (FTZ != 0);

  // classification; the hidden bit at [MAN_W] plays no part
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             ones_a, ones_b, zexp_a, zexp_b;
  logic             inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
  logic             seb;

  assign frac_a = bus.i_man_a[MAN_W-1:0];
  assign frac_b = bus.i_man_b[MAN_W-1:0];
  assign ones_a = &bus.i_exp_a;
  assign ones_b = &bus.i_exp_b;
  assign zexp_a = ~|bus.i_exp_a;
  assign zexp_b = ~|bus.i_exp_b;

  assign inf_a  = ones_a & ~|frac_a;
  assign inf_b  = ones_b & ~|frac_b;
  assign nan_a  = ones_a &  |frac_a;
  assign nan_b  = ones_b &  |frac_b;
  assign snan_a = nan_a & ~frac_a[MAN_W-1];
  assign snan_b = nan_b & ~frac_b[MAN_W-1];
  assign zero_a = zexp_a & (~|frac_a | FTZ_EN);
  assign zero_b = zexp_b & (~|frac_b | FTZ_EN);

  assign seb = bus.i_sign_b ^ bus.i_add_sub;

  beat_t res;

  always_comb begin
    res = '0;
    if (nan_a | nan_b) begin
      res.sel  = SEL_NAN;
      res.expo = '1;
      res.man  = QNAN_MAN;
      res.inv  = snan_a | snan_b;
    end else if (inf_a & inf_b & (bus.i_sign_a != seb)) begin
      res.sel  = SEL_NAN;
      res.expo = '1;
      res.man  = QNAN_MAN;
      res.inv  = 1'b1;
    end else if (inf_a) begin
      res.sel  = SEL_INF;
      res.sign = bus.i_sign_a;
      res.expo = '1;
    end else if (inf_b) begin
      res.sel  = SEL_INF;
      res.sign = seb;
      res.expo = '1;
    end else if (zero_a & zero_b) begin
      res.sel  = SEL_PASS;
      res.sign = bus.i_sign_a & seb;
    end else if (zero_a) begin
      res.sel  = SEL_PASS;
      res.sign = seb;
      res.expo = bus.i_exp_b;
      res.man  = bus.i_man_b;
    end else if (zero_b) begin
      res.sel  = SEL_PASS;
      res.sign = bus.i_sign_a;
      res.expo = bus.i_exp_a;
      res.man  = bus.i_man_a;
    end
  end

  // pipeline; stage k may load when it is empty or everything downstream of it can move
  logic [LAT-1:0] v_q, v_d, src_v, rdy;
  beat_t          data_q [LAT];
  beat_t          data_d [LAT];
  beat_t          src_d  [LAT];

  for (genvar g = 0; g < LAT; g++) begin : g_rdy
    assign rdy[g] = bus.i_ready | ~(&v_q[LAT-1:g]);
  end

  always_comb begin
    src_v = '0;
    for (int k = 0; k < LAT; k++) src_d[k] = '0;
    src_v[0] = bus.i_valid;
    src_d[0] = res;
    for (int k = 1; k < LAT; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = data_q[k-1];
    end
    for (int k = 0; k < LAT; k++) begin
      v_d[k]    = rdy[k] ? src_v[k] : v_q[k];
      data_d[k] = rdy[k] ? src_d[k] : data_q[k];
    end
  end

  // sticky flags and counter; a delivery in the same cycle as a clear survives it
  logic             hs_out;
  beat_t            out_beat;
  logic             flag_inv_q, flag_inv_d, flag_inf_q, flag_inf_d;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

  assign out_beat = data_q[LAT-1];
  assign hs_out   = v_q[LAT-1] & bus.i_ready;

  always_comb begin
    flag_inv_d = bus.i_flag_clr ? 1'b0 : flag_inv_q;
    flag_inf_d = bus.i_flag_clr ? 1'b0 : flag_inf_q;
    nan_cnt_d  = bus.i_flag_clr ? '0   : nan_cnt_q;
    if (hs_out) begin
      if (out_beat.inv) flag_inv_d = 1'b1;
      if (out_beat.sel == SEL_INF) flag_inf_d = 1'b1;
      if ((out_beat.sel == SEL_NAN) && (nan_cnt_d != '1)) nan_cnt_d = nan_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q        <= '0;
      for (int k = 0; k < LAT; k++) data_q[k] <= '0;
      flag_inv_q <= 1'b0;
      flag_inf_q <= 1'b0;
      nan_cnt_q  <= '0;
    end else begin
      v_q        <= v_d;
      for (int k = 0; k < LAT; k++) data_q[k] <= data_d[k];
      flag_inv_q <= flag_inv_d;
      flag_inf_q <= flag_inf_d;
      nan_cnt_q  <= nan_cnt_d;
    end
  end

  assign bus.o_ready        = rdy[0];
  assign bus.o_valid        = v_q[LAT-1];
  assign bus.o_sel          = out_beat.sel;
  assign bus.o_sign         = out_beat.sign;
  assign bus.o_exp          = out_beat.expo;
  assign bus.o_man          = out_beat.man;
  assign bus.o_flag_invalid = flag_inv_q;
  assign bus.o_flag_inf     = flag_inf_q;
  assign bus.o_nan_cnt      = nan_cnt_q;

endmodule

// File: tb/tb_fpu_special_case_pipe.sv
// Bench for fpu_special_case_pipe: two instances (LAT=2/FTZ=1/CNT_W=16 and LAT=3/FTZ=0/CNT_W=2)
// checked against a rule-level reference model with a scoreboard per instance.
module tb_fpu_special_case_pipe;
  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int LAT0 = 2;
  localparam int LAT1 = 3;
  localparam int CW0  = 16;
  localparam int CW1  = 2;

  typedef struct packed {
    logic [1:0]    sel;
    logic          sign;
    logic [EW-1:0] ex;
    logic [MW:0]   man;
    logic          inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_special_case_pipe_if #(.EXP_W(EW), .MAN_W(MW), .CNT_W(CW0)) bus0 ();
  fpu_special_case_pipe_if #(.EXP_W(EW), .MAN_W(MW), .CNT_W(CW1)) bus1 ();

  fpu_special_case_pipe #(.EXP_W(EW), .MAN_W(MW), .LAT(LAT0), .FTZ(1), .CNT_W(CW0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0)
  );
  fpu_special_case_pipe #(.EXP_W(EW), .MAN_W(MW), .LAT(LAT1), .FTZ(0), .CNT_W(CW1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  logic          drv_valid, drv_sub, drv_clr, tgt1, rdy0, rdy1;
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW:0]   ma, mb;

  assign bus0.i_valid    = drv_valid & ~tgt1;
  assign bus1.i_valid    = drv_valid & tgt1;
  assign bus0.i_ready    = rdy0;
  assign bus1.i_ready    = rdy1;
  assign bus0.i_flag_clr = drv_clr;
  assign bus1.i_flag_clr = drv_clr;
  assign bus0.i_add_sub  = drv_sub;
  assign bus1.i_add_sub  = drv_sub;
  assign bus0.i_sign_a = sa;  assign bus0.i_exp_a = ea;  assign bus0.i_man_a = ma;
  assign bus0.i_sign_b = sb;  assign bus0.i_exp_b = eb;  assign bus0.i_man_b = mb;
  assign bus1.i_sign_a = sa;  assign bus1.i_exp_a = ea;  assign bus1.i_man_a = ma;
  assign bus1.i_sign_b = sb;  assign bus1.i_exp_b = eb;  assign bus1.i_man_b = mb;

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int          hs_cnt [2];
  logic        m_inv  [2];
  logic        m_inf  [2];
  int          m_cnt  [2];
  logic [34:0] last_res [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
  endfunction

  // 0 zero, 1 finite non-zero, 2 inf, 3 quiet NaN, 4 signalling NaN
  function automatic int cls(input logic [EW-1:0] e, input logic [MW-1:0] f, input bit ftz);
    if (e == '1) begin
      if (f == '0) return 2;
      return f[MW-1] ? 3 : 4;
    end
    if (e == '0 && (f == '0 || ftz)) return 0;
    return 1;
  endfunction

  function automatic exp_t model(input logic xsa, input logic [EW-1:0] xea, input logic [MW:0] xma,
                                 input logic xsb, input logic [EW-1:0] xeb, input logic [MW:0] xmb,
                                 input logic sub, input bit ftz);
    exp_t r;
    int   ca, cb;
    logic seff;
    ca   = cls(xea, xma[MW-1:0], ftz);
    cb   = cls(xeb, xmb[MW-1:0], ftz);
    seff = xsb ^ sub;
    r    = '0;
    if (ca >= 3 || cb >= 3 || (ca == 2 && cb == 2 && xsa != seff)) begin
      r.sel = 2'b01; r.ex = '1; r.man[MW-1] = 1'b1;
      r.inv = (ca == 4 || cb == 4 || (ca == 2 && cb == 2));
    end else if (ca == 2 || cb == 2) begin
      r.sel = 2'b10; r.ex = '1; r.sign = (ca == 2) ? xsa : seff;
    end else if (ca == 0 && cb == 0) begin
      r.sel = 2'b11; r.sign = xsa & seff;
    end else if (ca == 0) begin
      r.sel = 2'b11; r.sign = seff; r.ex = xeb; r.man = xmb;
    end else if (cb == 0) begin
      r.sel = 2'b11; r.sign = xsa; r.ex = xea; r.man = xma;
    end
    return r;
  endfunction

  function automatic logic [EW+MW+1:0] rand_op();
    logic          s;
    logic [EW-1:0] e;
    logic [MW:0]   m;
    s = 1'($urandom_range(0, 1));
    e = EW'($urandom_range(1, 254));
    m = (MW+1)'($urandom);
    case ($urandom_range(0, 7))
      0: begin e = '0; m[MW-1:0] = '0; end
      1: begin e = '0; m[0] = 1'b1; end
      2: begin e = '1; m[MW-1:0] = '0; end
      3: begin e = '1; m[MW-1] = 1'b1; end
      4: begin e = '1; m[MW-1] = 1'b0; m[0] = 1'b1; end
      default: m[MW] = 1'b1;
    endcase
    return {s, e, m};
  endfunction

  // inputs are already applied; sample just after the falling edge, update model, advance a cycle
  task automatic step();
    logic [34:0] got  [2];
    logic        ov   [2];
    logic        ordy [2];
    logic        ivld [2];
    logic        irdy [2];
    logic        finv [2];
    logic        finf [2];
    int          fcnt [2];
    exp_t        e;
    logic        n_inv, n_inf;
    int          n_cnt, qs;
    #1;
    got[0] = {bus0.o_sel, bus0.o_sign, bus0.o_exp, bus0.o_man};
    got[1] = {bus1.o_sel, bus1.o_sign, bus1.o_exp, bus1.o_man};
    ov[0] = bus0.o_valid;   ov[1] = bus1.o_valid;
    ordy[0] = bus0.o_ready; ordy[1] = bus1.o_ready;
    ivld[0] = bus0.i_valid; ivld[1] = bus1.i_valid;
    irdy[0] = rdy0;         irdy[1] = rdy1;
    finv[0] = bus0.o_flag_invalid; finv[1] = bus1.o_flag_invalid;
    finf[0] = bus0.o_flag_inf;     finf[1] = bus1.o_flag_inf;
    fcnt[0] = int'(bus0.o_nan_cnt); fcnt[1] = int'(bus1.o_nan_cnt);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (d == 0) q0.delete(); else q1.delete();
        m_inv[d] = 1'b0; m_inf[d] = 1'b0; m_cnt[d] = 0;
      end else begin
        qs = (d == 0) ? q0.size() : q1.size();
        check_val("flag_invalid", finv[d], m_inv[d]);
        check_val("flag_inf", finf[d], m_inf[d]);
        check_val("nan_cnt", fcnt[d], m_cnt[d]);
        check_val("o_ready", ordy[d], irdy[d] | (qs < lat_of(d)));
        n_inv = drv_clr ? 1'b0 : m_inv[d];
        n_inf = drv_clr ? 1'b0 : m_inf[d];
        n_cnt = drv_clr ? 0 : m_cnt[d];
        if (ov[d] && irdy[d]) begin
          hs_cnt[d]++;
          if (qs == 0) begin
            check_val("spurious_out", ov[d], 1'b0);
          end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            check_val((d == 0) ? "result0" : "result1", got[d], {e.sel, e.sign, e.ex, e.man});
            last_res[d] = got[d];
            if (e.inv) n_inv = 1'b1;
            if (e.sel == 2'b10) n_inf = 1'b1;
            if (e.sel == 2'b01 && n_cnt < cnt_max(d)) n_cnt++;
          end
        end
        if (ivld[d] && ordy[d]) begin
          if (d == 0) q0.push_back(model(sa, ea, ma, sb, eb, mb, drv_sub, 1'b1));
          else        q1.push_back(model(sa, ea, ma, sb, eb, mb, drv_sub, 1'b0));
        end
        m_inv[d] = n_inv; m_inf[d] = n_inf; m_cnt[d] = n_cnt;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_flags();
    drv_valid = 1'b0; drv_clr = 1'b1;
    step();
    drv_clr = 1'b0;
  endtask

  task automatic one_beat(input int d, input logic sub, input logic [32:0] a, input logic [32:0] b,
                          input logic [34:0] want, input string tag);
    int n, start;
    tgt1 = (d == 1); rdy0 = 1'b1; rdy1 = 1'b1;
    drv_sub = sub; {sa, ea, ma} = a; {sb, eb, mb} = b;
    drv_valid = 1'b1;
    start = hs_cnt[d];
    step();
    drv_valid = 1'b0;
    n = 0;
    while (hs_cnt[d] == start && n < 10) begin
      step();
      n++;
    end
    check_val({tag, "_lat"}, n, lat_of(d));
    check_val(tag, last_res[d], want);
    step();
  endtask

  localparam logic [32:0] P_INF = {1'b0, 8'hFF, 24'h800000};
  localparam logic [32:0] N_INF = {1'b1, 8'hFF, 24'h800000};
  localparam logic [32:0] ONE   = {1'b0, 8'h7F, 24'h800000};
  localparam logic [32:0] TWO   = {1'b0, 8'h80, 24'h800000};
  localparam logic [32:0] P_Z   = {1'b0, 8'h00, 24'h000000};
  localparam logic [32:0] N_Z   = {1'b1, 8'h00, 24'h000000};
  localparam logic [32:0] QNAN  = {1'b0, 8'hFF, 24'hC00000};
  localparam logic [32:0] SNAN  = {1'b0, 8'hFF, 24'h800001};
  localparam logic [32:0] SUBN  = {1'b0, 8'h00, 24'h000001};
  localparam logic [34:0] R_QNAN = {2'b01, 1'b0, 8'hFF, 24'h400000};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] bp_ops [4];
    int acc;
    rst = 1'b1; drv_valid = 1'b0; drv_sub = 1'b0; drv_clr = 1'b0; tgt1 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    {sa, ea, ma} = '0; {sb, eb, mb} = '0;
    for (int d = 0; d < 2; d++) begin
      hs_cnt[d] = 0; m_inv[d] = 1'b0; m_inf[d] = 1'b0; m_cnt[d] = 0; last_res[d] = '0;
    end
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    #1;
    check_val("rst_valid0", bus0.o_valid, 1'b0);
    check_val("rst_valid1", bus1.o_valid, 1'b0);
    check_val("rst_ready0", bus0.o_ready, 1'b1);
    check_val("rst_inv", bus0.o_flag_invalid, 1'b0);
    check_val("rst_cnt", bus0.o_nan_cnt, 0);

    one_beat(0, 1'b0, P_INF, N_INF, R_QNAN, "inf_minus_inf");
    check_val("infinf_inv", bus0.o_flag_invalid, 1'b1);
    check_val("infinf_cnt", bus0.o_nan_cnt, 1);

    clear_flags();
    one_beat(0, 1'b1, ONE, P_INF, {2'b10, 1'b1, 8'hFF, 24'h0}, "inf_prop");
    check_val("infprop_inf", bus0.o_flag_inf, 1'b1);
    check_val("infprop_inv", bus0.o_flag_invalid, 1'b0);

    one_beat(0, 1'b1, N_Z, P_Z, {2'b11, 1'b1, 8'h00, 24'h0}, "nz_sub_pz");
    one_beat(0, 1'b0, N_Z, P_Z, {2'b11, 1'b0, 8'h00, 24'h0}, "nz_add_pz");
    one_beat(0, 1'b1, P_Z, TWO, {2'b11, 1'b1, 8'h80, 24'h800000}, "z_sub_two");
    one_beat(0, 1'b0, ONE, ONE, {2'b00, 1'b0, 8'h00, 24'h0}, "one_plus_one");
    one_beat(0, 1'b0, ONE, SUBN, {2'b11, 1'b0, 8'h7F, 24'h800000}, "ftz_sub_b");
    one_beat(1, 1'b0, ONE, SUBN, {2'b00, 1'b0, 8'h00, 24'h0}, "noftz_sub_b");
    one_beat(1, 1'b1, P_INF, ONE, {2'b10, 1'b0, 8'hFF, 24'h0}, "inf_a_lat3");

    // three quiet NaNs, then a signalling NaN delivered in the same cycle as a clear
    clear_flags();
    for (int i = 0; i < 3; i++) one_beat(0, 1'b0, QNAN, ONE, R_QNAN, "qnan");
    check_val("qnan_cnt3", bus0.o_nan_cnt, 3);
    check_val("qnan_inv", bus0.o_flag_invalid, 1'b0);
    tgt1 = 1'b0; rdy0 = 1'b1; {sa, ea, ma} = ONE; {sb, eb, mb} = SNAN; drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    step();
    check_val("snan_at_out", bus0.o_valid, 1'b1);
    drv_clr = 1'b1;
    step();
    drv_clr = 1'b0;
    check_val("clr_vs_evt_cnt", bus0.o_nan_cnt, 1);
    check_val("clr_vs_evt_inv", bus0.o_flag_invalid, 1'b1);

    // 2-bit counter saturates
    clear_flags();
    tgt1 = 1'b1; rdy1 = 1'b1; {sa, ea, ma} = QNAN; {sb, eb, mb} = TWO; drv_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    drv_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_val("sat_cnt", bus1.o_nan_cnt, 3);

    // backpressure: two stages fill, then o_ready drops
    bp_ops[0] = P_INF; bp_ops[1] = N_INF; bp_ops[2] = TWO; bp_ops[3] = N_Z;
    tgt1 = 1'b0; rdy0 = 1'b0; drv_sub = 1'b0; {sb, eb, mb} = ONE; acc = 0;
    for (int i = 0; i < 4; i++) begin
      {sa, ea, ma} = bp_ops[acc];
      drv_valid = 1'b1;
      #1;
      check_val("bp_ready", bus0.o_ready, (acc < 2));
      step();
      if (acc < 2) acc++;
    end
    drv_valid = 1'b0; rdy0 = 1'b1;
    check_val("bp_out_a", bus0.o_valid, 1'b1);
    step();
    check_val("bp_out_b", bus0.o_valid, 1'b1);
    step();
    check_val("bp_empty", bus0.o_valid, 1'b0);
    step();

    // reset with two beats in flight
    rdy0 = 1'b0; {sa, ea, ma} = QNAN; drv_valid = 1'b1;
    step(); step();
    drv_valid = 1'b0;
    check_val("pre_rst_valid", bus0.o_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("post_rst_valid", bus0.o_valid, 1'b0);
    check_val("post_rst_inf", bus0.o_flag_inf, 1'b0);
    check_val("post_rst_cnt", bus0.o_nan_cnt, 0);
    rdy0 = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // randomized traffic on both instances
    for (int i = 0; i < 800; i++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      tgt1      = 1'($urandom_range(0, 1));
      rdy0      = ($urandom_range(0, 2) != 0);
      rdy1      = ($urandom_range(0, 2) != 0);
      drv_clr   = ($urandom_range(0, 39) == 0);
      drv_sub   = 1'($urandom_range(0, 1));
      {sa, ea, ma} = rand_op();
      {sb, eb, mb} = rand_op();
      step();
    end
    drv_valid = 1'b0; drv_clr = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_val("drain0", q0.size(), 0);
    check_val("drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
